// File: rtl/div_issue_ctrl_if.sv
// Divide-issue bundle: execute-stage request/response plus engine in/out channels.
// slave = controller view, master = execute stage and divide engine view.
interface div_issue_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [1:0]       req_op_i;
    logic [WIDTH-1:0] req_a_i;
    logic [WIDTH-1:0] req_b_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [WIDTH-1:0] rsp_data_o;
    logic             rsp_err_o;
    logic             div_in_valid_o;
    logic             div_in_ready_i;
    logic [WIDTH-1:0] div_a_o;
    logic [WIDTH-1:0] div_b_o;
    logic             div_out_valid_i;
    logic             div_out_ready_o;
    logic [WIDTH-1:0] div_q_i;
    logic [WIDTH-1:0] div_r_i;

    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i,
        input  rsp_ready_i,
        input  div_in_ready_i,
        input  div_out_valid_i, div_q_i, div_r_i,
        output req_ready_o,
        output rsp_valid_o, rsp_data_o, rsp_err_o,
        output div_in_valid_o, div_a_o, div_b_o,
        output div_out_ready_o
    );

    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i,
        output rsp_ready_i,
        output div_in_ready_i,
        output div_out_valid_i, div_q_i, div_r_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_data_o, rsp_err_o,
        input  div_in_valid_o, div_a_o, div_b_o,
        input  div_out_ready_o
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// RISC-V M-extension divide initiator: sign handling, div-by-zero/overflow
// bypass, engine handshake with watchdog, sign restore and response hold.
module div_issue_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input logic           clock,
    input logic           reset,
    div_issue_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FIX,
        RESP
    } state_t;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic             op_rem;
    logic             sign_q;
    logic             sign_r;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [CW-1:0]    cnt;

    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             ovf;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign is_signed = ~bus.req_op_i[0];
    assign a_neg     = is_signed & bus.req_a_i[WIDTH-1];
    assign b_neg     = is_signed & bus.req_b_i[WIDTH-1];
    assign a_mag     = a_neg ? -bus.req_a_i : bus.req_a_i;
    assign b_mag     = b_neg ? -bus.req_b_i : bus.req_b_i;
    assign div_zero  = (bus.req_b_i == '0);
    assign ovf       = is_signed & (bus.req_a_i == MIN) & (bus.req_b_i == ONES);
    assign q_fix     = sign_q ? -q_reg : q_reg;
    assign r_fix     = sign_r ? -r_reg : r_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= IDLE;
            op_rem              <= 1'b0;
            sign_q              <= 1'b0;
            sign_r              <= 1'b0;
            q_reg               <= '0;
            r_reg               <= '0;
            cnt                 <= '0;
            bus.req_ready_o     <= 1'b1;
            bus.rsp_valid_o     <= 1'b0;
            bus.rsp_err_o       <= 1'b0;
            bus.rsp_data_o      <= '0;
            bus.div_in_valid_o  <= 1'b0;
            bus.div_a_o         <= '0;
            bus.div_b_o         <= '0;
            bus.div_out_ready_o <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    // stale engine results are accepted and dropped here
                    if (bus.req_valid_i) begin
                        bus.req_ready_o     <= 1'b0;
                        bus.div_out_ready_o <= 1'b0;
                        op_rem              <= bus.req_op_i[1];
                        sign_q              <= a_neg ^ b_neg;
                        sign_r              <= a_neg;
                        if (div_zero) begin
                            bus.rsp_data_o  <= bus.req_op_i[1] ? bus.req_a_i : ONES;
                            bus.rsp_err_o   <= 1'b0;
                            bus.rsp_valid_o <= 1'b1;
                            state           <= RESP;
                        end else if (ovf) begin
                            bus.rsp_data_o  <= bus.req_op_i[1] ? '0 : bus.req_a_i;
                            bus.rsp_err_o   <= 1'b0;
                            bus.rsp_valid_o <= 1'b1;
                            state           <= RESP;
                        end else begin
                            bus.div_a_o        <= a_mag;
                            bus.div_b_o        <= b_mag;
                            bus.div_in_valid_o <= 1'b1;
                            state              <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.div_in_ready_i) begin
                        bus.div_in_valid_o  <= 1'b0;
                        bus.div_out_ready_o <= 1'b1;
                        cnt                 <= '0;
                        state               <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.div_out_valid_i) begin
                        q_reg               <= bus.div_q_i;
                        r_reg               <= bus.div_r_i;
                        bus.div_out_ready_o <= 1'b0;
                        state               <= FIX;
                    end else if (TIMEOUT != 0 && cnt == LAST) begin
                        bus.rsp_data_o      <= '0;
                        bus.rsp_err_o       <= 1'b1;
                        bus.rsp_valid_o     <= 1'b1;
                        bus.div_out_ready_o <= 1'b0;
                        state               <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FIX: begin
                    bus.rsp_data_o  <= op_rem ? r_fix : q_fix;
                    bus.rsp_err_o   <= 1'b0;
                    bus.rsp_valid_o <= 1'b1;
                    state           <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        bus.rsp_valid_o     <= 1'b0;
                        bus.rsp_err_o       <= 1'b0;
                        bus.req_ready_o     <= 1'b1;
                        bus.div_out_ready_o <= 1'b1;
                        state               <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: engine path, bypasses, stalls,
// watchdog abort with late-result drain, and mid-operation reset.
module tb_div_issue_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    div_issue_ctrl_if #(.WIDTH(32)) bus ();

    div_issue_ctrl #(
        .WIDTH   (32),
        .TIMEOUT (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        @(negedge clock);
        check("req_ready_idle", 32'(bus.req_ready_o), 32'd1);
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = op;
        bus.req_a_i     = a;
        bus.req_b_i     = b;
        @(negedge clock);
        bus.req_valid_i = 1'b0;
        check("req_ready_busy", 32'(bus.req_ready_o), 32'd0);
    endtask

    task automatic issue(input logic [31:0] ea, input logic [31:0] eb);
        check("in_valid", 32'(bus.div_in_valid_o), 32'd1);
        check("div_a", bus.div_a_o, ea);
        check("div_b", bus.div_b_o, eb);
        bus.div_in_ready_i = 1'b1;
        @(negedge clock);
        bus.div_in_ready_i = 1'b0;
        check("in_valid_drop", 32'(bus.div_in_valid_o), 32'd0);
    endtask

    task automatic reply(input logic [31:0] q, input logic [31:0] r);
        check("out_ready_wait", 32'(bus.div_out_ready_o), 32'd1);
        bus.div_out_valid_i = 1'b1;
        bus.div_q_i         = q;
        bus.div_r_i         = r;
        @(negedge clock);
        bus.div_out_valid_i = 1'b0;
        check("fix_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
    endtask

    task automatic take(input string tag, input logic [31:0] data,
                        input logic err);
        int n = 0;
        while (!bus.rsp_valid_o && n < 30) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_valid"}, 32'(bus.rsp_valid_o), 32'd1);
        check({tag, "_data"}, bus.rsp_data_o, data);
        check({tag, "_err"}, 32'(bus.rsp_err_o), 32'(err));
        bus.rsp_ready_i = 1'b1;
        @(negedge clock);
        bus.rsp_ready_i = 1'b0;
        check({tag, "_clr"}, 32'(bus.rsp_valid_o), 32'd0);
        check({tag, "_err_clr"}, 32'(bus.rsp_err_o), 32'd0);
    endtask

    task automatic bypass(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        accept(op, a, b);
        check({tag, "_lat"}, 32'(bus.rsp_valid_o), 32'd1);
        check({tag, "_noeng"}, 32'(bus.div_in_valid_o), 32'd0);
        take(tag, exp, 1'b0);
        check({tag, "_noeng2"}, 32'(bus.div_in_valid_o), 32'd0);
    endtask

    task automatic reset_vals(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready_o), 32'd1);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'd0);
        check({tag, "_rsp_err"}, 32'(bus.rsp_err_o), 32'd0);
        check({tag, "_rsp_data"}, bus.rsp_data_o, 32'd0);
        check({tag, "_in_valid"}, 32'(bus.div_in_valid_o), 32'd0);
        check({tag, "_div_a"}, bus.div_a_o, 32'd0);
        check({tag, "_div_b"}, bus.div_b_o, 32'd0);
        check({tag, "_out_ready"}, 32'(bus.div_out_ready_o), 32'd1);
    endtask

    initial begin
        bus.req_valid_i     = 1'b0;
        bus.req_op_i        = 2'b00;
        bus.req_a_i         = '0;
        bus.req_b_i         = '0;
        bus.rsp_ready_i     = 1'b0;
        bus.div_in_ready_i  = 1'b0;
        bus.div_out_valid_i = 1'b0;
        bus.div_q_i         = '0;
        bus.div_r_i         = '0;

        repeat (2) @(negedge clock);
        reset_vals("rst");
        reset = 1'b0;

        // DIV -7/2 and REM -7/2
        accept(2'b00, 32'hFFFF_FFF9, 32'd2);
        issue(32'd7, 32'd2);
        reply(32'd3, 32'd1);
        take("div_m7_2", 32'hFFFF_FFFD, 1'b0);
        accept(2'b10, 32'hFFFF_FFF9, 32'd2);
        issue(32'd7, 32'd2);
        reply(32'd3, 32'd1);
        take("rem_m7_2", 32'hFFFF_FFFF, 1'b0);

        // DIV 7/-2 -> -3, REM 7/-2 -> 1
        accept(2'b00, 32'd7, 32'hFFFF_FFFE);
        issue(32'd7, 32'd2);
        reply(32'd3, 32'd1);
        take("div_7_m2", 32'hFFFF_FFFD, 1'b0);
        accept(2'b10, 32'd7, 32'hFFFF_FFFE);
        issue(32'd7, 32'd2);
        reply(32'd3, 32'd1);
        take("rem_7_m2", 32'd1, 1'b0);

        // DIVU treats the top bit as magnitude
        accept(2'b01, 32'hFFFF_FFF9, 32'd2);
        issue(32'hFFFF_FFF9, 32'd2);
        reply(32'h7FFF_FFFC, 32'd1);
        take("divu_big", 32'h7FFF_FFFC, 1'b0);

        // Local bypasses
        bypass("divu_z", 2'b01, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF);
        bypass("remu_z", 2'b11, 32'h8000_0000, 32'd0, 32'h8000_0000);
        bypass("div_z", 2'b00, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
        bypass("rem_z", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
        bypass("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        bypass("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Engine input stall, then response stall
        accept(2'b01, 32'd1000, 32'd10);
        for (int i = 0; i < 5; i++) begin
            check("stall_in_valid", 32'(bus.div_in_valid_o), 32'd1);
            check("stall_a", bus.div_a_o, 32'd1000);
            check("stall_b", bus.div_b_o, 32'd10);
            @(negedge clock);
        end
        issue(32'd1000, 32'd10);
        reply(32'd100, 32'd0);
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", 32'(bus.rsp_valid_o), 32'd1);
            check("hold_data", bus.rsp_data_o, 32'd100);
            @(negedge clock);
        end
        take("stall", 32'd100, 1'b0);

        // Watchdog: engine silent for 8 WAIT cycles
        accept(2'b01, 32'd50, 32'd5);
        issue(32'd50, 32'd5);
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            check("wd_pending", 32'(bus.rsp_valid_o), 32'd0);
        end
        @(negedge clock);
        check("wd_fire", 32'(bus.rsp_valid_o), 32'd1);
        take("wd", 32'd0, 1'b1);

        // Late engine result drained in IDLE
        check("drain_ready", 32'(bus.div_out_ready_o), 32'd1);
        bus.div_out_valid_i = 1'b1;
        bus.div_q_i         = 32'd10;
        bus.div_r_i         = 32'd0;
        @(negedge clock);
        bus.div_out_valid_i = 1'b0;
        check("drain_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
        check("drain_idle", 32'(bus.req_ready_o), 32'd1);

        // Reset pulsed during WAIT
        accept(2'b01, 32'd77, 32'd7);
        issue(32'd77, 32'd7);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        reset_vals("midrst");
        accept(2'b01, 32'd100, 32'd7);
        issue(32'd100, 32'd7);
        reply(32'd14, 32'd2);
        take("divu_100_7", 32'd14, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
